// File: rtl/isp_loader_pkg.sv
// Shared definitions for the ISP loader: FSM encoding, frame-length cap, checksum target.
package isp_loader_defs;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, WORD, WRITE, CSUM, GO, ERR
  } state_t;

  localparam logic [7:0] CHECKSUM_OK = 8'h00;

  // Largest legal word count for a program memory with `ab` address bits.
  function automatic logic [16:0] frame_len_cap(input int unsigned ab);
    return 17'(1) << ab;
  endfunction

  localparam logic [16:0] FRAME_LEN_CAP = frame_len_cap(12);

endpackage

// File: rtl/isp_word_assembler.sv
// Little-endian byte-to-word packer with byte counter and running 8-bit checksum.
module isp_word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  seed,
  input  logic                  add,
  input  logic                  shift,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  last_byte,
  output logic [7:0]            sum
);

  logic [DATA_WIDTH-1:0] word;
  logic [1:0]            byte_cnt;

  // Word with the current byte merged in, so the FSM can capture it on the 4th byte.
  always_comb begin
    word_next = word;
    word_next[{byte_cnt, 3'b000} +: 8] = byte_in;
  end

  assign last_byte = (byte_cnt == 2'd3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= '0;
      sum      <= '0;
    end else if (seed) begin
      word     <= '0;
      byte_cnt <= '0;
      sum      <= byte_in;
    end else begin
      if (add) sum <= sum + byte_in;
      if (shift) begin
        word     <= word_next;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/isp_loader.sv
// Framed byte-stream program loader: writes words into core program memory, then starts the core.
module isp_loader
  import isp_loader_defs::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDRESS_BITS = 12,
  parameter logic [19:0] PROG_BASE    = 20'h00000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    isp_write,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    core_reset,
  output logic                    start,
  output logic [19:0]             prog_address,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam logic [16:0] LEN_CAP = frame_len_cap(ADDRESS_BITS);

  state_t state, next;
  logic [15:0] len;
  logic [16:0] wcnt;
  logic [15:0] n_full;
  logic [7:0]  csum_next;
  logic        acc;

  logic [DATA_WIDTH-1:0] word_next;
  logic                  last_byte;
  logic [7:0]            sum;

  logic rdy_d, wr_d, start_d, busy_d, done_d, err_d, crst_d;

  assign acc          = rx_valid && rx_ready;
  assign n_full       = {rx_data, len[7:0]};
  assign csum_next    = sum + rx_data;
  assign prog_address = PROG_BASE;

  isp_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clock    (clock),
    .reset    (reset),
    .seed     (acc && state == IDLE),
    .add      (acc && state != IDLE),
    .shift    (acc && state == WORD),
    .byte_in  (rx_data),
    .word_next(word_next),
    .last_byte(last_byte),
    .sum      (sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:   if (acc) next = LEN_HI;
      LEN_HI: if (acc) begin
        if ({1'b0, n_full} > LEN_CAP) next = ERR;
        else if (n_full == 16'd0)     next = CSUM;
        else                          next = WORD;
      end
      WORD:   if (acc && last_byte) next = WRITE;
      WRITE:  next = (wcnt + 17'd1 == {1'b0, len}) ? CSUM : WORD;
      CSUM:   if (acc) next = (csum_next == CHECKSUM_OK) ? GO : ERR;
      default: next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    rdy_d   = (next == IDLE) || (next == LEN_HI) || (next == WORD) || (next == CSUM);
    wr_d    = (next == WRITE);
    start_d = (next == GO);
    busy_d  = busy;
    done_d  = done;
    err_d   = error;
    crst_d  = core_reset;
    if (state == IDLE && acc) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      err_d  = 1'b0;
      crst_d = 1'b1;
    end
    if (next == GO) begin
      crst_d = 1'b0;
      done_d = 1'b1;
      busy_d = 1'b0;
    end
    if (next == ERR) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_ready    <= 1'b0;
      isp_write   <= 1'b0;
      isp_address <= '0;
      isp_data    <= '0;
      core_reset  <= 1'b1;
      start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      len         <= '0;
      wcnt        <= '0;
    end else begin
      rx_ready   <= rdy_d;
      isp_write  <= wr_d;
      start      <= start_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= err_d;
      core_reset <= crst_d;
      if (wr_d) begin
        isp_address <= wcnt[ADDRESS_BITS-1:0];
        isp_data    <= word_next;
      end
      if (state == IDLE && acc) len <= {8'h00, rx_data};
      if (state == LEN_HI && acc) begin
        len[15:8] <= rx_data;
        wcnt      <= '0;
      end
      if (state == WRITE) wcnt <= wcnt + 17'd1;
    end
  end

endmodule

// File: tb/tb_isp_loader.sv
// Directed bench for isp_loader: good frames, bad checksum, zero/oversize length, mid-frame reset.
module tb_isp_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        isp_write;
  logic [11:0] isp_address;
  logic [31:0] isp_data;
  logic        core_reset;
  logic        start;
  logic [19:0] prog_address;
  logic        busy, done, error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int acc_cyc = 0;
  logic        start_crst;
  logic [19:0] start_pa;
  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];

  isp_loader dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .isp_write   (isp_write),
    .isp_address (isp_address),
    .isp_data    (isp_data),
    .core_reset  (core_reset),
    .start       (start),
    .prog_address(prog_address),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (isp_write) begin
      wa_q.push_back(isp_address);
      wd_q.push_back(isp_data);
    end
    if (start) begin
      start_cnt  <= start_cnt + 1;
      start_cyc  <= cyc;
      start_crst <= core_reset;
      start_pa   <= prog_address;
    end
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    start_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge right after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int to;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    to = 0;
    while (!rx_ready && to < 20) begin
      @(negedge clock);
      to++;
    end
    if (to >= 20) begin
      checks++; errors++;
      $display("FAIL send_byte timeout: rx_ready=%b required 1", rx_ready);
    end
    acc_cyc = cyc;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({rx_ready, isp_write, core_reset, start, busy, done, error} !== 7'b0010000) begin
      errors++;
      $display("FAIL %s flags: rdy,wr,crst,start,busy,done,err=%b required 0010000", tag,
               {rx_ready, isp_write, core_reset, start, busy, done, error});
    end
    checks++;
    if (isp_address !== 12'h000 || isp_data !== 32'h0 || prog_address !== 20'h0) begin
      errors++;
      $display("FAIL %s regs: addr=%h data=%h pa=%h required 000/00000000/00000", tag,
               isp_address, isp_data, prog_address);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: rx_ready=%b required 1", rx_ready);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] f[7] = '{8'h01, 8'h00, 8'h37, 8'h11, 8'h00, 8'h00, 8'hB7};
    clear_log();
    for (int i = 0; i < 6; i++) send_byte(f[i], 0);
    checks++;
    if (isp_write !== 1'b1 || isp_address !== 12'h000 || isp_data !== 32'h00001137) begin
      errors++;
      $display("FAIL single_write_latency: wr=%b addr=%h data=%h required 1/000/00001137",
               isp_write, isp_address, isp_data);
    end
    send_byte(f[6], 0);
    checks++;
    if (start !== 1'b1 || core_reset !== 1'b0 || prog_address !== 20'h0) begin
      errors++;
      $display("FAIL single_start: start=%b crst=%b pa=%h required 1/0/00000", start, core_reset, prog_address);
    end
    @(negedge clock);
    checks++;
    if (start !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL single_after: start=%b done=%b busy=%b crst=%b required 0/1/0/0", start, done, busy, core_reset);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (wa_q.size() !== 1 || start_cnt !== 1 || isp_data !== 32'h00001137) begin
      errors++;
      $display("FAIL single_totals: writes=%0d starts=%0d data=%h required 1/1/00001137",
               wa_q.size(), start_cnt, isp_data);
    end
  endtask

  task automatic test_two_words();
    logic [7:0] f[11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                          8'h13, 8'h01, 8'h20, 8'h00, 8'h27};
    int gaps[11] = '{0, 3, 1, 2, 0, 3, 2, 1, 0, 1, 2};
    clear_log();
    for (int i = 0; i < 11; i++) send_byte(f[i], gaps[i]);
    repeat (4) @(negedge clock);
    checks++;
    if (wa_q.size() !== 2) begin
      errors++; $display("FAIL two_count: writes=%0d required 2", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 12'h000 || wd_q[0] !== 32'h00100093) begin
        errors++; $display("FAIL two_w0: addr=%h data=%h required 000/00100093", wa_q[0], wd_q[0]);
      end
      checks++;
      if (wa_q[1] !== 12'h001 || wd_q[1] !== 32'h00200113) begin
        errors++; $display("FAIL two_w1: addr=%h data=%h required 001/00200113", wa_q[1], wd_q[1]);
      end
    end
    checks++;
    if (start_cnt !== 1 || start_crst !== 1'b0 || start_pa !== 20'h0 || done !== 1'b1) begin
      errors++;
      $display("FAIL two_start: starts=%0d crst=%b pa=%h done=%b required 1/0/00000/1",
               start_cnt, start_crst, start_pa, done);
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] f[7] = '{8'h01, 8'h00, 8'h37, 8'h11, 8'h00, 8'h00, 8'hB8};
    clear_log();
    for (int i = 0; i < 7; i++) send_byte(f[i], 0);
    checks++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum_err: error=%b rdy=%b crst=%b required 1/0/1", error, rx_ready, core_reset);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (start_cnt !== 0 || done !== 1'b0 || busy !== 1'b0 || error !== 1'b1 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum_after: starts=%0d done=%b busy=%b err=%b crst=%b required 0/0/0/1/1",
               start_cnt, done, busy, error, core_reset);
    end
  endtask

  task automatic test_zero_len();
    int first_acc;
    clear_log();
    send_byte(8'h00, 0);
    first_acc = acc_cyc;
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL zero_busy: busy=%b err=%b required 1/0", busy, error);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge clock);
    checks++;
    if (start_cnt !== 1 || start_cyc - first_acc !== 3 || wa_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_len: starts=%0d start_delay=%0d writes=%0d required 1/3/0",
               start_cnt, start_cyc - first_acc, wa_q.size());
    end
  endtask

  task automatic test_too_long();
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    checks++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL too_long_err: error=%b rdy=%b busy=%b required 1/0/0", error, rx_ready, busy);
    end
    @(negedge clock);
    checks++;
    if (rx_ready !== 1'b1 || wa_q.size() !== 0 || start_cnt !== 0) begin
      errors++;
      $display("FAIL too_long_after: rdy=%b writes=%0d starts=%0d required 1/0/0", rx_ready, wa_q.size(), start_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] f[7] = '{8'h01, 8'h00, 8'h37, 8'h11, 8'h00, 8'h00, 8'hB7};
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 1);
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    clear_log();
    for (int i = 0; i < 7; i++) send_byte(f[i], i % 2);
    repeat (3) @(negedge clock);
    checks++;
    if (wa_q.size() !== 1 || start_cnt !== 1 || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reload: writes=%0d starts=%0d done=%b required 1/1/1", wa_q.size(), start_cnt, done);
    end else begin
      checks++;
      if (wa_q[0] !== 12'h000 || wd_q[0] !== 32'h00001137) begin
        errors++;
        $display("FAIL reset_mid_word: addr=%h data=%h required 000/00001137", wa_q[0], wd_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_bad_csum();
    test_zero_len();
    test_too_long();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
